// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage (master) and IMEM (slave).
// A transfer completes on any rising edge where IMemReq and IMemReady are both high.
interface instr_fetch_stage_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemRData;

    modport master (output IMemReq, output IMemAddr, input IMemReady, input IMemRData);
    modport slave  (input IMemReq, input IMemAddr, output IMemReady, output IMemRData);
endinterface

// File: rtl/instr_fetch_stage.sv
// RV32 instruction fetch stage: IF/ID register, one-entry skid buffer for decode stalls,
// and redirect handling that discards a fetch still in flight when the redirect arrives.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Stall,
    input  logic                       Redirect,
    input  logic [31:0]                RedirectPC,
    instr_fetch_stage_if.master        imem,
    output logic                       InstrValid,
    output logic [31:0]                Instr,
    output logic [31:0]                PC,
    output logic [31:0]                PCPlus4,
    output logic [6:0]                 OpCode,
    output logic [4:0]                 Rd,
    output logic [2:0]                 Funct3,
    output logic [4:0]                 Rs1,
    output logic [4:0]                 Rs2,
    output logic [6:0]                 Funct7
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_SKID  = 1'b1
    } state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_addr, w_addr_nx;
    logic        r_drop, w_drop_nx;
    logic [31:0] r_tgt, w_tgt_nx;
    logic [31:0] r_skid_instr, w_skid_instr_nx;
    logic [31:0] r_skid_pc, w_skid_pc_nx;
    logic        r_valid, w_valid_nx;
    logic [31:0] r_instr, w_instr_nx;
    logic [31:0] r_pc, w_pc_nx;

    logic        w_req;
    logic        w_done;
    logic [31:0] w_target;

    // Gated by rst so the first request appears in the very first cycle after reset.
    assign w_req    = (r_state == S_FETCH) && !rst;
    assign w_done   = w_req && imem.IMemReady;
    assign w_target = RedirectPC & ~32'h3;

    always_comb begin
        w_state_nx      = r_state;
        w_addr_nx       = r_addr;
        w_drop_nx       = r_drop;
        w_tgt_nx        = r_tgt;
        w_skid_instr_nx = r_skid_instr;
        w_skid_pc_nx    = r_skid_pc;
        w_valid_nx      = r_valid;
        w_instr_nx      = r_instr;
        w_pc_nx         = r_pc;

        if (Redirect) begin
            w_state_nx = S_FETCH;
            w_valid_nx = 1'b0;
            w_instr_nx = NOP_INSTR;
            // An outstanding request must keep its address until it completes.
            if (w_req && !w_done) begin
                w_drop_nx = 1'b1;
                w_tgt_nx  = w_target;
            end else begin
                w_drop_nx = 1'b0;
                w_addr_nx = w_target;
            end
        end else if (r_state == S_SKID) begin
            if (!Stall) begin
                w_valid_nx = 1'b1;
                w_instr_nx = r_skid_instr;
                w_pc_nx    = r_skid_pc;
                w_state_nx = S_FETCH;
            end
        end else if (w_done && r_drop) begin
            w_drop_nx = 1'b0;
            w_addr_nx = r_tgt;
            if (!Stall) begin
                w_valid_nx = 1'b0;
                w_instr_nx = NOP_INSTR;
            end
        end else if (w_done) begin
            w_addr_nx = r_addr + 32'd4;
            if (!Stall || !r_valid) begin
                w_valid_nx = 1'b1;
                w_instr_nx = imem.IMemRData;
                w_pc_nx    = r_addr;
            end else begin
                w_skid_instr_nx = imem.IMemRData;
                w_skid_pc_nx    = r_addr;
                w_state_nx      = S_SKID;
            end
        end else if (!Stall) begin
            w_valid_nx = 1'b0;
            w_instr_nx = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= RESET_PC;
            r_drop       <= 1'b0;
            r_tgt        <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_valid      <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_pc         <= RESET_PC;
        end else begin
            r_addr       <= w_addr_nx;
            r_drop       <= w_drop_nx;
            r_tgt        <= w_tgt_nx;
            r_skid_instr <= w_skid_instr_nx;
            r_skid_pc    <= w_skid_pc_nx;
            r_valid      <= w_valid_nx;
            r_instr      <= w_instr_nx;
            r_pc         <= w_pc_nx;
        end
    end

    assign imem.IMemReq  = w_req;
    assign imem.IMemAddr = r_addr;
    assign InstrValid    = r_valid;
    assign Instr         = r_instr;
    assign PC            = r_pc;
    assign PCPlus4       = r_pc + 32'd4;
    assign OpCode        = r_instr[6:0];
    assign Rd            = r_instr[11:7];
    assign Funct3        = r_instr[14:12];
    assign Rs1           = r_instr[19:15];
    assign Rs2           = r_instr[24:20];
    assign Funct7        = r_instr[31:25];

endmodule
